// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-lite encodings and the register-bank arbiter FSM state type.
// Contents:
//   HADDR_WIDTH / HDATA_WIDTH  fixed 32-bit bus widths
//   HTRANS_*                   transfer type encodings
//   HBURST_SINGLE, HSIZE_WORD  constant burst/size used for every transfer
//   HRESP_*                    slave response encodings (bit 0 = ERROR)
//   HPROT_DATA_PRIV            constant protection attribute
//   arb_state_t                ARB -> ADDR -> DATA -> RESP
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam int HADDR_WIDTH = 32;
    localparam int HDATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Data access, privileged, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

endpackage : ahb_pkg

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: grants the first set request at or
// after ptr_i, wrapping modulo N_REQ. The pointer register lives in the parent.
// Ports:
//   req_i      [N_REQ-1:0]  request vector
//   ptr_i      [IDX_W-1:0]  highest-priority index (must be < N_REQ)
//   en_i                    grant allowed this cycle
//   gnt_o      [N_REQ-1:0]  one-hot grant (zero when disabled or idle)
//   gnt_idx_o  [IDX_W-1:0]  encoded grant index (zero when no grant)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic             found;
    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        pos       = 0;
        pos_idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            pos = int'(ptr_i) + off;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (en_i && !found && req_i[pos_idx]) begin
                found          = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                gnt_idx_o      = pos_idx;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/ahb_reg_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_reg_arbiter
// Shares one AHB-lite register-bank slave between N_REQ internal requesters.
// Requests are accepted round-robin in ARB and issued as single 32-bit NONSEQ
// transfers, one at a time: ARB -> ADDR -> DATA -> RESP -> ARB.
// Optional build macro AHB_ARB_TIMEOUT_EN adds a data-phase watchdog that
// aborts a transfer with an error after TIMEOUT_CYCLES stalled cycles.
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   req_valid_i/write_i      per-requester request valid and direction
//   req_addr_i/wdata_i       packed per requester, requester k at [k*32+:32]
//   req_ready_o              one-hot accept pulse (combinational, ARB only)
//   rsp_valid_o              one-hot completion pulse
//   rsp_rdata_o, rsp_err_o   response data/error, valid with rsp_valid_o
//   h*_o                     AHB-lite master outputs
//   hready_o                 feeds the slave's hreadyi (mirrors hreadyo_i)
//   hreadyo_i/hresp_i/hrdata_i  AHB-lite slave response
// ----------------------------------------------------------------------------
module ahb_reg_arbiter
    import ahb_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ-1:0]             req_write_i,
    input  logic [N_REQ*HADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*HDATA_WIDTH-1:0] req_wdata_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic [N_REQ-1:0]             rsp_valid_o,
    output logic [HDATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic                         hsel_o,
    output logic [HADDR_WIDTH-1:0]       haddr_o,
    output logic                         hwrite_o,
    output logic [1:0]                   htrans_o,
    output logic [2:0]                   hsize_o,
    output logic [2:0]                   hburst_o,
    output logic [3:0]                   hprot_o,
    output logic                         hmastlock_o,
    output logic [HDATA_WIDTH-1:0]       hwdata_o,
    output logic                         hready_o,
    input  logic                         hreadyo_i,
    input  logic [1:0]                   hresp_i,
    input  logic [HDATA_WIDTH-1:0]       hrdata_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [HADDR_WIDTH-1:0] addr_q, addr_d;
    logic                   write_q, write_d;
    logic [HDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [HDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [N_REQ-1:0]       gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   timeout_hit;

    logic [HADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [HDATA_WIDTH-1:0] wdata_arr [N_REQ];

    // hresp_i[1] is not part of the AHB-lite response encoding.
    logic unused_hresp;
    assign unused_hresp = hresp_i[1];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign addr_arr[k]  = req_addr_i[k*HADDR_WIDTH +: HADDR_WIDTH];
        assign wdata_arr[k] = req_wdata_i[k*HDATA_WIDTH +: HDATA_WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (state_q == ARB),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            stalled;

    // Counts stalled ADDR/DATA cycles; ARB always precedes ADDR, so clearing
    // there gives a fresh count on every ADDR entry. The hit fires on the
    // stalled cycle that brings the count to TIMEOUT_CYCLES.
    always_comb begin
        stalled     = ((state_q == ADDR) || (state_q == DATA)) && !hreadyo_i;
        to_cnt_d    = to_cnt_q;
        timeout_hit = stalled && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        if (state_q == ARB) begin
            to_cnt_d = '0;
        end else if (stalled) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ARB: begin
                if (|req_valid_i) begin
                    idx_d   = gnt_idx;
                    addr_d  = addr_arr[gnt_idx];
                    write_d = req_write_i[gnt_idx];
                    wdata_d = wdata_arr[gnt_idx];
                    ptr_d   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (hreadyo_i) begin
                    state_d = DATA;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            DATA: begin
                if (hreadyo_i) begin
                    // Error or write responses never carry read data upward.
                    err_d   = hresp_i[0];
                    rdata_d = (!write_q && !hresp_i[0]) ? hrdata_i : '0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ARB;
            ptr_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = gnt;
    assign rsp_valid_o = (state_q == RESP) ? (N_REQ'(1) << idx_q) : '0;
    assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err_o   = (state_q == RESP) && err_q;

    assign hsel_o      = (state_q == ADDR);
    assign haddr_o     = (state_q == ADDR) ? addr_q : '0;
    assign hwrite_o    = (state_q == ADDR) && write_q;
    assign htrans_o    = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsize_o     = HSIZE_WORD;
    assign hburst_o    = HBURST_SINGLE;
    assign hprot_o     = HPROT_DATA_PRIV;
    assign hmastlock_o = 1'b0;
    assign hwdata_o    = ((state_q == DATA) && write_q) ? wdata_q : '0;
    assign hready_o    = hreadyo_i;

endmodule : ahb_reg_arbiter

// File: tb/tb_ahb_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_reg_arbiter
// Self-checking bench for ahb_reg_arbiter (N_REQ=3, TIMEOUT_CYCLES=64).
// Table-driven single transfers plus hand-written sequences for round-robin
// fairness, reset during the data phase and (with AHB_ARB_TIMEOUT_EN) the
// watchdog abort. The bench drives the slave side directly.
// ----------------------------------------------------------------------------
module tb_ahb_reg_arbiter;
    import ahb_pkg::*;

    localparam int N = 3;

    typedef struct {
        int          req;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] slv_rdata;
        int          aw;
        int          dw;
        bit          err;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [N-1:0]  req_valid_i = '0;
    logic [N-1:0]  req_write_i = '0;
    logic [N*32-1:0] req_addr_i;
    logic [N*32-1:0] req_wdata_i;
    logic [N-1:0]  req_ready_o;
    logic [N-1:0]  rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          hsel_o;
    logic [31:0]   haddr_o;
    logic          hwrite_o;
    logic [1:0]    htrans_o;
    logic [2:0]    hsize_o;
    logic [2:0]    hburst_o;
    logic [3:0]    hprot_o;
    logic          hmastlock_o;
    logic [31:0]   hwdata_o;
    logic          hready_o;
    logic          hreadyo_i = 1'b1;
    logic [1:0]    hresp_i = 2'b00;
    logic [31:0]   hrdata_i = '0;

    logic [31:0] addr_arr  [N];
    logic [31:0] wdata_arr [N];

    int checks = 0;
    int failures = 0;
    vec_t vecs [6];

    assign req_addr_i  = {addr_arr[2], addr_arr[1], addr_arr[0]};
    assign req_wdata_i = {wdata_arr[2], wdata_arr[1], wdata_arr[0]};

    always #5 clk_i = ~clk_i;

    ahb_reg_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .hsel_o      (hsel_o),
        .haddr_o     (haddr_o),
        .hwrite_o    (hwrite_o),
        .htrans_o    (htrans_o),
        .hsize_o     (hsize_o),
        .hburst_o    (hburst_o),
        .hprot_o     (hprot_o),
        .hmastlock_o (hmastlock_o),
        .hwdata_o    (hwdata_o),
        .hready_o    (hready_o),
        .hreadyo_i   (hreadyo_i),
        .hresp_i     (hresp_i),
        .hrdata_i    (hrdata_i)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, ".hsel"}, 32'(hsel_o), 32'd0);
        checkOutput({tag, ".htrans"}, 32'(htrans_o), 32'd0);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    endtask

    // One complete transfer from a single requester, checked cycle by cycle.
    // Cycle 0 = accept (ARB), 1 = ADDR, then ADDR waits, DATA cycles, RESP.
    task automatic applyStimulus(input vec_t v);
        logic [N-1:0] onehot;
        logic [31:0]  exp_wdata;
        onehot    = N'(1) << v.req;
        exp_wdata = v.wr ? v.wdata : 32'h0;

        @(negedge clk_i);
        req_valid_i         = onehot;
        req_write_i         = onehot & {N{v.wr}};
        addr_arr[v.req]     = v.addr;
        wdata_arr[v.req]    = v.wdata;
        hreadyo_i           = 1'b1;
        hresp_i             = HRESP_OKAY;
        hrdata_i            = 32'h0;
        #1;
        checkOutput("accept.req_ready", 32'(req_ready_o), 32'(onehot));

        // Requester withdraws and scribbles its inputs; transfer must not care.
        @(negedge clk_i);
        req_valid_i      = '0;
        req_write_i      = '0;
        addr_arr[v.req]  = 32'hBAD0_0000;
        wdata_arr[v.req] = 32'hBAD0_0001;
        hreadyo_i        = (v.aw == 0);
        #1;
        checkOutput("addr.hsel", 32'(hsel_o), 32'd1);
        checkOutput("addr.htrans", 32'(htrans_o), 32'(2'b10));
        checkOutput("addr.haddr", haddr_o, v.addr);
        checkOutput("addr.hwrite", 32'(hwrite_o), 32'(v.wr));
        checkOutput("addr.hready_o", 32'(hready_o), 32'(hreadyo_i));
        for (int i = 0; i < v.aw; i++) begin
            @(negedge clk_i);
            hreadyo_i = (i == v.aw - 1);
            #1;
            checkOutput("addrwait.hsel", 32'(hsel_o), 32'd1);
            checkOutput("addrwait.haddr", haddr_o, v.addr);
        end

        for (int i = 0; i <= v.dw; i++) begin
            @(negedge clk_i);
            hreadyo_i = (i == v.dw);
            hresp_i   = v.err ? HRESP_ERROR : HRESP_OKAY;
            hrdata_i  = (i == v.dw) ? v.slv_rdata : 32'hFFFF_0000;
            #1;
            checkOutput("data.hsel", 32'(hsel_o), 32'd0);
            checkOutput("data.htrans", 32'(htrans_o), 32'd0);
            checkOutput("data.hwdata", hwdata_o, exp_wdata);
            checkOutput("data.rsp_valid", 32'(rsp_valid_o), 32'd0);
        end

        @(negedge clk_i);
        hreadyo_i = 1'b1;
        hresp_i   = HRESP_OKAY;
        hrdata_i  = 32'h0;
        #1;
        checkOutput("resp.rsp_valid", 32'(rsp_valid_o), 32'(onehot));
        checkOutput("resp.rsp_rdata", rsp_rdata_o, v.exp_rdata);
        checkOutput("resp.rsp_err", 32'(rsp_err_o), 32'(v.exp_err));

        @(negedge clk_i);
        #1;
        checkIdleBus("after");
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic [N-1:0] exp_gnt;
        int           rsp_cycle;

        //            req wr addr          wdata         slv_rdata     aw dw err exp_rdata     exp_err
        vecs[0] = '{1, 0, 32'h0000_0008, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 0};
        vecs[1] = '{0, 1, 32'h0000_0004, 32'h1234_5678, 32'h5555_5555, 0, 2, 0, 32'h0,        0};
        vecs[2] = '{2, 0, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 0, 1, 1, 32'h0,        1};
        vecs[3] = '{1, 0, 32'h0000_0014, 32'h0,        32'hA5A5_5A5A, 2, 1, 0, 32'hA5A5_5A5A, 0};
        vecs[4] = '{2, 1, 32'h0000_0020, 32'h0F0F_F0F0, 32'h7777_7777, 0, 1, 1, 32'h0,        1};
        vecs[5] = '{0, 0, 32'hFFFF_FFFC, 32'h0,        32'h0000_0001, 1, 0, 0, 32'h0000_0001, 0};

        for (int k = 0; k < N; k++) begin
            addr_arr[k]  = 32'h0;
            wdata_arr[k] = 32'h0;
        end

        // Reset state.
        repeat (2) @(negedge clk_i);
        #1;
        checkIdleBus("reset");
        checkOutput("reset.hsize", 32'(hsize_o), 32'(3'b010));
        checkOutput("reset.hburst", 32'(hburst_o), 32'd0);
        checkOutput("reset.hprot", 32'(hprot_o), 32'(4'b0011));
        checkOutput("reset.hmastlock", 32'(hmastlock_o), 32'd0);
        checkOutput("reset.hready_o", 32'(hready_o), 32'd1);
        checkOutput("reset.rsp_err", 32'(rsp_err_o), 32'd0);
        checkOutput("reset.rsp_rdata", rsp_rdata_o, 32'd0);
        checkOutput("reset.haddr", haddr_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        // Round robin: all requesters valid, expect grants 0,1,2,0,1,2 every 4 cycles.
        $display("[TB] round robin");
        doReset();
        @(negedge clk_i);
        req_valid_i = 3'b111;
        req_write_i = 3'b000;
        hreadyo_i   = 1'b1;
        hresp_i     = HRESP_OKAY;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            #1;
            exp_gnt = (cyc % 4 == 0) ? (N'(1) << ((cyc / 4) % 3)) : '0;
            checkOutput("rr.req_ready", 32'(req_ready_o), 32'(exp_gnt));
            exp_gnt = (cyc % 4 == 3) ? (N'(1) << ((cyc / 4) % 3)) : '0;
            checkOutput("rr.rsp_valid", 32'(rsp_valid_o), 32'(exp_gnt));
        end
        @(negedge clk_i);
        req_valid_i = '0;

        // Reset asserted during DATA: bus idles at once, no response, pointer back to 0.
        $display("[TB] reset during data");
        @(negedge clk_i);
        req_valid_i = 3'b001;
        #1;
        checkOutput("rst.accept", 32'(req_ready_o), 32'(3'b001));
        @(negedge clk_i);
        req_valid_i = '0;
        @(negedge clk_i);
        hreadyo_i = 1'b0;
        #1;
        checkOutput("rst.in_data_htrans", 32'(htrans_o), 32'd0);
        rstn_i = 1'b0;
        #1;
        checkIdleBus("rst.async");
        checkOutput("rst.haddr", haddr_o, 32'd0);
        @(negedge clk_i);
        rstn_i    = 1'b1;
        hreadyo_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            checkIdleBus("rst.after");
        end
        req_valid_i = 3'b101;
        #1;
        checkOutput("rst.ptr0_grant", 32'(req_ready_o), 32'(3'b001));
        @(negedge clk_i);
        req_valid_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("rst.next_rsp", 32'(rsp_valid_o), 32'(3'b001));
        @(negedge clk_i);

`ifdef AHB_ARB_TIMEOUT_EN
        // Watchdog: slave never ready; abort response 65 cycles after accept.
        $display("[TB] timeout");
        @(negedge clk_i);
        req_valid_i = 3'b010;
        hreadyo_i   = 1'b0;
        #1;
        checkOutput("to.accept", 32'(req_ready_o), 32'(3'b010));
        rsp_cycle = -1;
        for (int cyc = 1; cyc < 100; cyc++) begin
            @(negedge clk_i);
            req_valid_i = '0;
            #1;
            if (rsp_valid_o != '0) begin
                rsp_cycle = cyc;
                checkOutput("to.rsp_valid", 32'(rsp_valid_o), 32'(3'b010));
                checkOutput("to.rsp_err", 32'(rsp_err_o), 32'd1);
                checkOutput("to.rsp_rdata", rsp_rdata_o, 32'd0);
                break;
            end
        end
        checkOutput("to.latency", 32'(rsp_cycle), 32'd65);
        @(negedge clk_i);
        hreadyo_i = 1'b1;
        #1;
        checkIdleBus("to.after");
`else
        rsp_cycle = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ahb_reg_arbiter

// File: doc/ahb_reg_arbiter.md
Name: ahb_reg_arbiter

Overview:
- Shares one AHB-lite register-bank slave (the PMU/SafeSU register bank) between N_REQ internal requesters, e.g. a configuration sequencer, a counter-snapshot engine and a debug port.
- Accepts simple valid/ready register requests, arbitrates them round-robin, and issues single 32-bit NONSEQ AHB-lite transfers, one at a time.
- Returns read data or an error per requester.
- Sits between the internal requesters and the register-bank slave port, acting as the only AHB master on that port.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- HADDR_WIDTH, 32, AHB address width (fixed, localparam).
- HDATA_WIDTH, 32, AHB data width (fixed, localparam).
- TIMEOUT_CYCLES, 64, data-phase watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset
- req_valid_i  in  N_REQ  request valid per requester
- req_write_i  in  N_REQ  1=write, 0=read
- req_addr_i  in  N_REQ*HADDR_WIDTH  byte address per requester, packed (requester k at bits [k*32+:32])
- req_wdata_i  in  N_REQ*HDATA_WIDTH  write data per requester, packed the same way
- req_ready_o  out  N_REQ  one-hot accept pulse
- rsp_valid_o  out  N_REQ  one-hot completion pulse
- rsp_rdata_o  out  HDATA_WIDTH  read data, valid with rsp_valid_o
- rsp_err_o  out  1  error flag, valid with rsp_valid_o
- hsel_o  out  1  slave select
- haddr_o  out  HADDR_WIDTH  address
- hwrite_o  out  1  write
- htrans_o  out  2  transfer type
- hsize_o  out  3  transfer size
- hburst_o  out  3  burst type
- hprot_o  out  4  protection
- hmastlock_o  out  1  locked access
- hwdata_o  out  HDATA_WIDTH  write data
- hready_o  out  1  drives the slave's hreadyi input
- hreadyo_i  in  1  slave hready
- hresp_i  in  2  slave response; bit 0 = ERROR
- hrdata_i  in  HDATA_WIDTH  slave read data

Behaviour:
- Reset is asynchronous, active-low on rstn_i; clock is clk_i.
- Reset values:
  - all outputs 0, except hready_o=1.
  - htrans_o=IDLE, hsize_o=3'b010 (constant), hburst_o=SINGLE (constant), hprot_o=4'b0011 (constant), hmastlock_o=0.
  - state=ARB; round-robin pointer=0 (requester 0 highest priority).
- FSM states: ARB, ADDR, DATA, RESP.
- ARB:
  - If any req_valid_i is set, grant the first valid requester at or after the pointer, wrapping modulo N_REQ.
  - Pulse req_ready_o[g] for one cycle in the same cycle (combinational from valid and pointer).
  - Register addr/write/wdata/g.
  - Move the pointer to g+1, wrapping N_REQ-1 to 0.
  - Go to ADDR.
  - No valid request: stay in ARB, all AHB controls idle (hsel_o=0, htrans_o=IDLE).
- ADDR:
  - Drive hsel_o=1, htrans_o=NONSEQ, haddr_o, hwrite_o.
  - If hreadyo_i=1, go to DATA; otherwise hold all address-phase signals stable.
- DATA:
  - Drive hsel_o=0, htrans_o=IDLE.
  - hwdata_o = captured wdata for writes, 0 for reads.
  - Wait while hreadyo_i=0.
  - On hreadyo_i=1: capture hrdata_i (reads only) and hresp_i[0] into registers, then go to RESP.
- RESP:
  - rsp_valid_o[g]=1 for exactly one cycle with the registered rsp_rdata_o and rsp_err_o.
  - rsp_rdata_o=0 on writes or on error.
  - Go to ARB.
- Latency: accept to rsp_valid_o is 3 cycles minimum (ADDR, DATA, RESP), plus any slave wait states.
- Two-cycle ERROR response (hresp ERROR with hready 0, then ERROR with hready 1): the transfer completes on the second cycle with rsp_err_o=1. Never retried.
- hready_o always equals hreadyo_i; a single master is the only master on this port.
- A requester deasserting req_valid_i after acceptance has no effect on the transfer in flight.
- A request arriving during ADDR/DATA/RESP waits; requests are accepted only in ARB. Minimum 4 cycles between accepts.
- Simultaneous requests: round-robin fairness. Each waiting requester is served within N_REQ grants.
- Reset mid-transfer: return to ARB immediately with all outputs at reset values. The in-flight response is lost and the requester must reissue.

Optional Feature:
- Macro: AHB_ARB_TIMEOUT_EN.
- With the macro: a cycle counter clears on entry to ADDR and counts each cycle spent in ADDR or DATA with hreadyo_i=0. When it reaches TIMEOUT_CYCLES, abort to RESP with rsp_err_o=1 and rsp_rdata_o=0.
- Without the macro: no counter, and the arbiter waits indefinitely.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HBURST_SINGLE
  - HSIZE_WORD
  - HRESP_OKAY/ERROR
  - HADDR_WIDTH/HDATA_WIDTH
  - arb_state_t enum {ARB, ADDR, DATA, RESP}
- Sub-module rr_arbiter:
  - Parameterised N_REQ; inputs request vector, pointer and enable; outputs one-hot grant and encoded index.
  - Purely combinational, pointer register kept in the parent.

Test Plan:
- Single read, requester 1, addr 0x8, slave returns 0xDEADBEEF with no wait states -> req_ready_o=3'b010 at cycle 0; rsp_valid_o=3'b010 at cycle 3; rsp_rdata_o=0xDEADBEEF; rsp_err_o=0.
- Write 0x12345678 to 0x4 from requester 0, slave inserts 2 wait states -> hwdata_o=0x12345678 is held throughout DATA; rsp_valid_o at cycle 5; rsp_err_o=0; hsel_o=0 during DATA.
- All three requesters valid continuously -> grant order 0,1,2,0,1,2; each grant is 4 cycles apart.
- Two-cycle ERROR response on a read -> rsp_err_o=1, rsp_rdata_o=0; the next request proceeds normally.
- rstn_i asserted during DATA -> next edge: state ARB, hsel_o=0, htrans_o=IDLE, pointer=0, no rsp_valid_o pulse.
- With AHB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, hreadyo_i held at 0 -> rsp_err_o=1 at cycle 65 after accept; the arbiter returns to ARB.
